// File: rtl/enc_dispatch.sv
// enc_dispatch: queues priority-encoder requests and issues one-hot grants.
// Build macro ENC_DISPATCH_DEDUP_EN drops requests already queued or granted.
module enc_dispatch #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             Y,
   input  logic                   valid,
   input  logic                   done,
   output logic [3:0]             gnt,
   output logic                   busy,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   timeout
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_REL
   } state_t;

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      return 4'b1000 >> idx;
   endfunction

   // request edge detector state
   logic          valid_q, valid_d;
   logic [1:0]    y_q, y_d;

   // FIFO state
   logic [1:0]    mem_q [DEPTH];
   logic [1:0]    mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   // FSM state
   state_t        state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          timeout_q, timeout_d;

   logic          push;
   logic          pop;
   logic          dup;
   logic          wr_ok;
   logic          drop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign busy     = (state_q != S_IDLE);
   assign count    = count_q;
   assign overflow = ovf_q;
   assign gnt      = gnt_q;
   assign timeout  = timeout_q;

   // A new request is a rising valid or a change of index while valid
   assign push = valid && (!valid_q || (Y != y_q));
   assign pop  = (state_q == S_IDLE) && !empty;

`ifdef ENC_DISPATCH_DEDUP_EN
   logic [PW-1:0] slot_off;
`endif

   // Flag a push whose index is already waiting or being serviced
   always_comb begin
      dup = 1'b0;
`ifdef ENC_DISPATCH_DEDUP_EN
      slot_off = '0;
      if ((state_q == S_GRANT) && (gnt_q == onehot(Y))) dup = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         slot_off = PW'(i) - rd_ptr_q;
         if (({1'b0, slot_off} < count_q) && (mem_q[i] == Y)) dup = 1'b1;
      end
`endif
   end

   // A full FIFO still takes a push when the head leaves the same cycle
   assign wr_ok = push && !dup && (!full || pop);
   assign drop  = push && !dup && full && !pop;

   // FIFO next-state: write at tail, advance head on pop, track occupancy
   always_comb begin
      valid_d  = valid;
      y_d      = Y;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q | drop;
      if (wr_ok) begin
         mem_d[wr_ptr_q] = Y;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({wr_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FSM next-state: grant the head, hold until done or timer expiry
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      timer_d   = timer_q;
      timeout_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_GRANT;
               gnt_d   = onehot(mem_q[rd_ptr_q]);
               timer_d = '0;
            end
         end
         S_GRANT: begin
            if (done) begin
               state_d = S_REL;
               gnt_d   = '0;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d   = S_REL;
               gnt_d     = '0;
               timeout_d = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_REL: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Register all state; reset flushes the queue and drops any grant
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q   <= 1'b0;
         y_q       <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         y_q       <= y_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_enc_dispatch.sv
// tb_enc_dispatch: directed stimulus with a grant scoreboard for enc_dispatch.
// Grant expectations are queued by the stimulus and checked by a monitor.
module tb_enc_dispatch;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] Y;
   logic       valid;
   logic       done;
   logic [3:0] gnt;
   logic       busy;
   logic       empty;
   logic       full;
   logic [2:0] count;
   logic       overflow;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] g;
      int         len;
      bit         to;
      int         gap;
   } exp_t;

   exp_t exp_q[$];

   enc_dispatch #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .Y        (Y),
      .valid    (valid),
      .done     (done),
      .gnt      (gnt),
      .busy     (busy),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic expect_gnt(input logic [3:0] g, input int len,
                             input bit to, input int gap);
      exp_t e;
      e.g   = g;
      e.len = len;
      e.to  = to;
      e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((busy || !empty || (gnt != 0)) && (n < 200)) begin
         tick();
         n++;
      end
      chk(nm, int'(busy), 0);
   endtask

   // Monitor: match each grant against the scoreboard on the falling edge
   initial begin : mon
      logic [3:0] prev_g;
      int         hi;
      int         gap;
      bit         have;
      exp_t       cur;
      prev_g = '0;
      hi     = 0;
      gap    = 0;
      have   = 1'b0;
      cur    = '{g: 4'b0, len: 0, to: 1'b0, gap: 0};
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_g = '0;
            hi     = 0;
            gap    = 0;
            have   = 1'b0;
         end else begin
            if ((gnt != 0) && (prev_g == 0)) begin
               hi = 1;
               if (exp_q.size() == 0) begin
                  chk("unexpected_gnt", int'(gnt), 0);
               end else begin
                  cur  = exp_q.pop_front();
                  have = 1'b1;
                  chk("gnt_value", int'(gnt), int'(cur.g));
                  if (cur.gap != 0) chk("gnt_gap", gap, cur.gap);
               end
            end else if (gnt != 0) begin
               hi++;
               if (gnt != prev_g) chk("gnt_stable", int'(gnt), int'(prev_g));
            end else if (prev_g != 0) begin
               if (have) begin
                  chk("gnt_len", hi, cur.len);
                  chk("timeout_pulse", int'(timeout), int'(cur.to));
               end
               have = 1'b0;
               gap  = 1;
            end else begin
               gap++;
               chk("timeout_idle", int'(timeout), 0);
            end
            prev_g = gnt;
         end
      end
   end

   // Stimulus
   initial begin : stim
      int         gcnt;
      logic [1:0] seq [6];

      rst   = 1'b0;
      valid = 1'b1;
      Y     = 2'b01;
      done  = 1'b0;

      // reset held with a live request on the inputs
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_gnt", int'(gnt), 0);
         chk("rst_empty", int'(empty), 1);
         chk("rst_count", int'(count), 0);
         chk("rst_overflow", int'(overflow), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_full", int'(full), 0);
         chk("rst_timeout", int'(timeout), 0);
      end

      // held valid pushes on the first cycle after release
      rst = 1'b1;
      expect_gnt(4'b0100, 8, 1'b1, 0);
      tick();
      chk("post_rst_count", int'(count), 1);
      valid = 1'b0;
      wait_idle("idle_post_rst");

      // single request, done on third grant cycle
      valid = 1'b1;
      Y     = 2'b10;
      gcnt  = 0;
      expect_gnt(4'b0010, 3, 1'b0, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (gnt != 0) gcnt++;
         done = (gnt != 0) && (gcnt == 3);
      end
      done  = 1'b0;
      valid = 1'b0;
      chk("single_gnt_cycles", gcnt, 3);
      chk("single_empty", int'(empty), 1);
      chk("single_busy", int'(busy), 0);

      // queue order: three back-to-back edges, done answers each grant
      expect_gnt(4'b1000, 1, 1'b0, 0);
      expect_gnt(4'b0001, 1, 1'b0, 2);
      expect_gnt(4'b0100, 1, 1'b0, 2);
      valid = 1'b1;
      Y     = 2'b00;
      tick();
      Y    = 2'b11;
      done = (gnt != 0);
      tick();
      Y    = 2'b01;
      done = (gnt != 0);
      tick();
      valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         done = (gnt != 0);
         tick();
      end
      done = 1'b0;
      wait_idle("idle_order");

      // timeout
      expect_gnt(4'b0001, 8, 1'b1, 0);
      valid = 1'b1;
      Y     = 2'b11;
      tick();
      valid = 1'b0;
      wait_idle("idle_timeout");
      chk("timeout_empty", int'(empty), 1);

      // overflow: six distinct edges, done never asserted
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      expect_gnt(4'b1000, 8, 1'b1, 0);
      expect_gnt(4'b0100, 8, 1'b1, 2);
      expect_gnt(4'b0010, 8, 1'b1, 2);
      expect_gnt(4'b0001, 8, 1'b1, 2);
`ifndef ENC_DISPATCH_DEDUP_EN
      expect_gnt(4'b1000, 8, 1'b1, 2);
`endif
      valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         Y = seq[k];
         tick();
      end
      valid = 1'b0;
`ifndef ENC_DISPATCH_DEDUP_EN
      chk("ovf_full", int'(full), 1);
      chk("ovf_count", int'(count), 4);
      chk("ovf_flag", int'(overflow), 1);
`else
      chk("ovf_full", int'(full), 0);
      chk("ovf_count", int'(count), 3);
      chk("ovf_flag", int'(overflow), 0);
`endif
      wait_idle("idle_ovf");
`ifndef ENC_DISPATCH_DEDUP_EN
      chk("ovf_sticky", int'(overflow), 1);
`else
      chk("ovf_sticky", int'(overflow), 0);
`endif
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("ovf_cleared", int'(overflow), 0);
      chk("ovf_rst_count", int'(count), 0);
      tick();

      // duplicate index while that index is granted
      expect_gnt(4'b0100, 8, 1'b1, 0);
`ifndef ENC_DISPATCH_DEDUP_EN
      expect_gnt(4'b0100, 8, 1'b1, 2);
      expect_gnt(4'b0100, 8, 1'b1, 2);
`endif
      valid = 1'b1;
      Y     = 2'b01;
      tick();
      valid = 1'b0;
      tick();
      chk("dedup_granted", int'(gnt), 4);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      valid = 1'b1;
      tick();
      valid = 1'b0;
`ifndef ENC_DISPATCH_DEDUP_EN
      chk("dedup_count", int'(count), 2);
`else
      chk("dedup_count", int'(count), 0);
`endif
      wait_idle("idle_dedup");

      tick();
      chk("sb_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
